// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES SubBytes engine.
//   - fsmState_t  : engine FSM states (IDLE / BUSY / DONE)
//   - AES_BYTE_W  : width of one AES byte (one S-box lane)
//   - AES_STATE_W : width of a full AES state
//   - paramsLegal : true when a state width splits evenly into S-box chunks
//   - beatsOf     : number of cycles needed to substitute a whole state
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BYTE_W  = 8;
    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsmState_t;

    // A configuration is usable only if every beat covers a whole chunk.
    function automatic bit paramsLegal(input int dataW, input int numSbox);
        return (numSbox > 0) && (dataW > 0) &&
               ((dataW % (AES_BYTE_W * numSbox)) == 0);
    endfunction

    function automatic int beatsOf(input int dataW, input int numSbox);
        return dataW / (AES_BYTE_W * numSbox);
    endfunction

endpackage

// File: rtl/aes_sbox_canright.sv
// ---------------------------------------------------------------------------
// aes_sbox_canright
// Combinational single-byte AES S-box covering both directions with one
// shared GF(2^8) inverter: the affine map is applied after the inversion for
// SubBytes and its inverse is applied before the inversion for InvSubBytes.
// Ports:
//   data_in  [7:0] : byte to substitute
//   enc_dec        : 1 = SubBytes, 0 = InvSubBytes
//   data_out [7:0] : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox_canright (
    input  logic [7:0] data_in,
    input  logic       enc_dec,
    output logic [7:0] data_out
);

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), built from the square
    // chain a^2 * a^4 * ... * a^128.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gfMul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affineFwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affineInv(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

    logic [7:0] invIn;
    logic [7:0] invOut;

    assign invIn    = enc_dec ? data_in : affineInv(data_in);
    assign invOut   = gfInv(invIn);
    assign data_out = enc_dec ? affineFwd(invOut) : invOut;

endmodule

// File: rtl/aes_subbytes_iter.sv
// ---------------------------------------------------------------------------
// aes_subbytes_iter
// Handshaked SubBytes / InvSubBytes engine for a DATA_W-bit AES state.
// NUM_SBOX shared S-box lanes are time-multiplexed over the state, MSB chunk
// first, so a full substitution takes BEATS = DATA_W/(8*NUM_SBOX) cycles.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : input handshake for data_in + enc_dec
//   data_in             : input state, byte i = data_in[DATA_W-1-8i -: 8]
//   enc_dec             : 1 = SubBytes, 0 = InvSubBytes, latched on accept
//   out_valid/out_ready : output handshake for data_out
//   data_out            : registered substituted state
//   busy                : high while chunks are being substituted
// ---------------------------------------------------------------------------
module aes_subbytes_iter
    import aes_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int NUM_SBOX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enc_dec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int CHUNK_W = AES_BYTE_W * NUM_SBOX;
    localparam int BEATS   = beatsOf(DATA_W, NUM_SBOX);
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!paramsLegal(DATA_W, NUM_SBOX)) begin : g_badParams
        $fatal(1, "aes_subbytes_iter: DATA_W must be a multiple of 8*NUM_SBOX");
    end

    fsmState_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [CHUNK_W-1:0] chunkIn;
    logic [CHUNK_W-1:0] chunkOut;
    logic               accept;
    logic               cntValid;

    // DONE can hand its slot straight to a new state when the consumer
    // takes the result on the same edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign data_out  = dout_q;
    assign cntValid  = (int'(cnt_q) < BEATS);

    // Select the chunk addressed by the beat counter; constant slices keep
    // every index in range even if the counter holds an unused encoding.
    always_comb begin
        chunkIn = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) chunkIn = work_q[DATA_W-1-b*CHUNK_W -: CHUNK_W];
        end
    end

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        aes_sbox_canright u_sbox (
            .data_in  (chunkIn[CHUNK_W-1-l*AES_BYTE_W -: AES_BYTE_W]),
            .enc_dec  (mode_q),
            .data_out (chunkOut[CHUNK_W-1-l*AES_BYTE_W -: AES_BYTE_W])
        );
    end

    // Next-state logic: load on accept, substitute one chunk per BUSY edge
    // in place, and publish the whole state to data_out only on the last beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    work_d  = data_in;
                    mode_d  = enc_dec;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!cntValid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) work_d[DATA_W-1-b*CHUNK_W -: CHUNK_W] = chunkOut;
                    end
                    if (int'(cnt_q) == BEATS - 1) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        dout_d  = work_d;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_subbytes_iter
// Drives three engines (NUM_SBOX = 4, 16, 1) with known-answer and random
// states. Expected results come from S-box tables built in the bench from
// the AES field definition, independently of the design's inverter.
// ---------------------------------------------------------------------------
module tb_aes_subbytes_iter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [2:0]        inValid;
    logic [2:0]        enc;
    logic [2:0]        outReady;
    logic [2:0][127:0] dataIn;
    wire  [2:0]        inReady;
    wire  [2:0]        outValid;
    wire  [2:0]        busy;
    wire  [2:0][127:0] dataOut;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [7:0] sboxTab [256];
    logic [7:0] invTab  [256];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    aes_subbytes_iter #(.DATA_W(128), .NUM_SBOX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .data_in(dataIn[0]), .enc_dec(enc[0]), .out_valid(outValid[0]),
        .out_ready(outReady[0]), .data_out(dataOut[0]), .busy(busy[0]));

    aes_subbytes_iter #(.DATA_W(128), .NUM_SBOX(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .data_in(dataIn[1]), .enc_dec(enc[1]), .out_valid(outValid[1]),
        .out_ready(outReady[1]), .data_out(dataOut[1]), .busy(busy[1]));

    aes_subbytes_iter #(.DATA_W(128), .NUM_SBOX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .data_in(dataIn[2]), .enc_dec(enc[2]), .out_valid(outValid[2]),
        .out_ready(outReady[2]), .data_out(dataOut[2]), .busy(busy[2]));

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Walks the multiplicative group with generator 3 (p) alongside its
    // inverse 1/3 (q), so sboxTab[p] = affine(1/p) without any inversion.
    task automatic buildTables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sboxTab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxTab[0] = 8'h63;
        for (int i = 0; i < 256; i++) invTab[sboxTab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] modelSub(input logic [127:0] din, input logic mode);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = din[127-8*i -: 8];
            r[127-8*i -: 8] = mode ? sboxTab[b] : invTab[b];
        end
        return r;
    endfunction

    function automatic int latOf(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers one state to engine d, optionally disturbs the inputs while it
    // works, checks latency and result, and optionally consumes the result.
    task automatic applyStimulus(input int d, input logic [127:0] din, input logic mode,
                                 input logic [127:0] expected, input bit disturb,
                                 input bit consume, input string tag);
        int waitCnt;
        int lat;
        @(negedge clk);
        dataIn[d]  = din;
        enc[d]     = mode;
        inValid[d] = 1'b1;
        waitCnt    = 0;
        while (!inReady[d] && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReady[d]) begin
            checkOutput({tag, " accept timeout"}, 128'd0, 128'd1);
            inValid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        inValid[d] = 1'b0;
        checkOutput({tag, " busy"}, 128'(busy[d]), 128'd1);
        if (disturb) begin
            enc[d]    = ~mode;
            dataIn[d] = rand128();
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid[d] && lat < 64);
        checkOutput({tag, " latency"}, 128'(lat), 128'(latOf(d)));
        checkOutput({tag, " data"}, dataOut[d], expected);
        if (consume) begin
            outReady[d] = 1'b1;
            @(negedge clk);
            outReady[d] = 1'b0;
            checkOutput({tag, " idle valid/ready"}, {126'd0, outValid[d], inReady[d]}, 128'b01);
        end
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] second;
        logic         m;
        bit           sawValid;
        int           lat;

        buildTables();
        rst_n    = 1'b0;
        inValid  = '0;
        enc      = '0;
        outReady = '0;
        dataIn   = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset flags %0d", d),
                        {125'd0, outValid[d], busy[d], inReady[d]}, 128'b001);
            checkOutput($sformatf("reset data %0d", d), dataOut[d], 128'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Known answers on every lane count, including input disturbance.
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, FIPS_IN, 1'b1, FIPS_OUT, 1'b0, 1'b1, $sformatf("fips enc %0d", d));
            applyStimulus(d, FIPS_OUT, 1'b0, FIPS_IN, 1'b1, 1'b1, $sformatf("fips dec %0d", d));
            applyStimulus(d, {16{8'h00}}, 1'b1, {16{8'h63}}, 1'b0, 1'b1, $sformatf("zeros %0d", d));
            applyStimulus(d, {16{8'h53}}, 1'b1, {16{8'hED}}, 1'b1, 1'b1, $sformatf("x53 %0d", d));
            applyStimulus(d, {16{8'h63}}, 1'b0, {16{8'h00}}, 1'b0, 1'b1, $sformatf("x63 dec %0d", d));
        end

        // Random states and modes against the table model.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 6; n++) begin
                r = rand128();
                m = 1'($urandom_range(0, 1));
                applyStimulus(d, r, m, modelSub(r, m), 1'($urandom_range(0, 1)), 1'b1,
                              $sformatf("rand %0d.%0d", d, n));
            end
        end

        // Backpressure in DONE with a pending input, then same-edge handoff.
        applyStimulus(0, FIPS_IN, 1'b1, FIPS_OUT, 1'b0, 1'b0, "bp first");
        second     = rand128();
        dataIn[0]  = second;
        enc[0]     = 1'b0;
        inValid[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp hold data", dataOut[0], FIPS_OUT);
            checkOutput("bp hold valid/ready", {126'd0, outValid[0], inReady[0]}, 128'b10);
        end
        outReady[0] = 1'b1;
        #1;
        checkOutput("bp handoff ready", 128'(inReady[0]), 128'd1);
        @(negedge clk);
        outReady[0] = 1'b0;
        inValid[0]  = 1'b0;
        checkOutput("bp handoff valid/busy", {126'd0, outValid[0], busy[0]}, 128'b01);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid[0] && lat < 64);
        checkOutput("bp second latency", 128'(lat), 128'd4);
        checkOutput("bp second data", dataOut[0], modelSub(second, 1'b0));
        outReady[0] = 1'b1;
        @(negedge clk);
        outReady[0] = 1'b0;

        // Reset asserted with two chunks done must abort without a result.
        dataIn[0]  = rand128();
        enc[0]     = 1'b1;
        inValid[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort busy before reset", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort flags", {125'd0, outValid[0], busy[0], inReady[0]}, 128'b001);
        checkOutput("abort data", dataOut[0], 128'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        sawValid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (outValid[0] || busy[0]) sawValid = 1'b1;
        end
        checkOutput("abort no stale result", 128'(sawValid), 128'd0);
        checkOutput("abort ready after release", 128'(inReady[0]), 128'd1);

        // Engine still works normally after the abort.
        applyStimulus(0, FIPS_IN, 1'b1, FIPS_OUT, 1'b0, 1'b1, "post-abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
